avr_cpu_alu_mul: RTL and testbench
==================================

AVR_CPU_ALU_MUL -- requirements
Module: avr_cpu_alu_mul

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal 4..32).
REQ-002 The module SHALL have input clk, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit: reset, which is synchronous and active-high.
REQ-004 The module SHALL have input start, 1 bit: a request to begin a multiply.
REQ-005 The module SHALL have input mode, 2 bits: 00 is unsigned x unsigned, 01 is signed x signed, 10 is signed d_in x unsigned r_in, and 11 is treated as 00.
REQ-006 The module SHALL have input frac, 1 bit: fractional multiply (FMUL family).
REQ-007 The module SHALL have inputs d_in and r_in, each WIDTH bits: the operands.
REQ-008 The module SHALL have input status_in, 8 bits: the SREG value.
REQ-009 The module SHALL have output busy, 1 bit: high while an operation is in progress.
REQ-010 The module SHALL have output done, 1 bit: a one-cycle completion pulse.
REQ-011 The module SHALL have output product, 2*WIDTH bits: the result.
REQ-012 The module SHALL have output status_out, 8 bits: SREG with C and Z updated.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 The FSM SHALL accept start only in IDLE or DONE; start asserted during RUN SHALL be ignored, with no queueing.
REQ-015 On an accepted start at edge k, the block SHALL latch d_in, r_in, mode and frac, clear the accumulator and enter RUN.
REQ-016 busy SHALL be 1 exactly in cycles k+1 .. k+WIDTH, one radix-2 shift-add step per cycle.
REQ-017 After step WIDTH the FSM SHALL enter DONE; done SHALL be 1 for exactly cycle k+WIDTH+1, then the FSM returns to IDLE unless start is asserted in that cycle.
REQ-018 In the DONE cycle, an asserted start SHALL be accepted back-to-back, so done and the next operation's busy never overlap.
REQ-019 product SHALL hold the previous result until the DONE edge, then update and stay stable until the next DONE.
REQ-020 Within a latency-(WIDTH+1) window, product SHALL be neither cleared nor partially visible.
REQ-021 Arithmetic SHALL be exact 2*WIDTH-bit two's-complement for signed operands; negative partial products SHALL use sign extension with a final correction step for a signed multiplier.
REQ-022 The raw product P SHALL be the full product; for frac=1, product = P << 1 with LSB 0 and the MSB discarded.
REQ-023 The C register SHALL be P[2*WIDTH-1] of the unshifted product.
REQ-024 The Z register SHALL be (product == 0) after any fractional shift.
REQ-025 status_out SHALL be combinational: status_in with bit0 = C register and bit1 = Z register.
REQ-026 C and Z registers SHALL update only at DONE and hold otherwise.
REQ-027 Operands changing while busy SHALL have no effect.
REQ-028 Boundary: signed x signed of the most-negative value with itself SHALL yield 2^(2W-2) with C=0 (WIDTH=8: 0x80*0x80 = 0x4000).
REQ-029 Boundary: any zero operand SHALL yield product 0 and Z=1.

Reset
REQ-030 rst SHALL have priority over start and any in-flight operation.
REQ-031 At reset the FSM SHALL be IDLE, busy=0, done=0, product=0, C=Z=0, and latched operands 0.
REQ-032 Reset mid-RUN SHALL abort with no done pulse and product 0.
REQ-033 start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-034 With macro AVR_CPU_ALU_FMUL_EN defined, frac SHALL behave as in REQ-022 to REQ-024.
REQ-035 Without AVR_CPU_ALU_FMUL_EN, frac SHALL be ignored (treated as 0), the shift logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-036 WIDTH=8, mode=00, d=0xFF, r=0xFF, start at cycle 0 -> busy in cycles 1..8, done in cycle 9, product=0xFE01, C=1, Z=0.
REQ-037 mode=01, d=0xFF (-1), r=0x02 -> product=0xFFFE, C=1; then mode=10, d=0xFF, r=0x02 -> product=0xFFFE (-1*2 signed x unsigned).
REQ-038 FMUL_EN defined, mode=01, frac=1, d=0x80, r=0x80 -> product=0x8000, C=0, Z=0; with the macro undefined, same stimulus -> 0x4000.
REQ-039 start asserted every cycle -> a new op begins only in DONE cycles, done every 9 cycles, and start during busy is ignored.
REQ-040 rst at cycle 4 of RUN -> busy=0, no done, product=0; next start completes normally.
REQ-041 d=0x00, r=0xA5, status_in=0xFF -> product=0, status_out=0xFE (C=0, Z=1, other bits passed).

Source files
------------

// File: rtl/avr_cpu_alu_mul.sv
// avr_cpu_alu_mul: sequential radix-2 shift-add multiplier for the AVR MUL family.
//
// Optional feature macro: AVR_CPU_ALU_FMUL_EN (enables the fractional FMUL shift).
//
// Ports:
//   clk        - clock, all registers update on the rising edge
//   rst        - synchronous active-high reset, overrides everything
//   start      - request a multiply (accepted in IDLE or DONE only)
//   mode       - 00 u*u, 01 s*s, 10 s(d)*u(r), 11 behaves as 00
//   frac       - fractional multiply (product shifted left by one)
//   d_in, r_in - operands, WIDTH bits each
//   status_in  - incoming SREG
//   busy       - high for the WIDTH shift-add cycles
//   done       - one-cycle completion pulse
//   product    - 2*WIDTH-bit result, updated only on completion
//   status_out - status_in with bit0 = C and bit1 = Z
module avr_cpu_alu_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 frac,
  input  logic [WIDTH-1:0]     d_in,
  input  logic [WIDTH-1:0]     r_in,
  input  logic [7:0]           status_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [7:0]           status_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand;     // multiplicand, pre-extended and shifted left each step
  logic [WIDTH-1:0] mult;     // multiplier, shifted right each step
  logic            r_signed;
  logic [CW-1:0]   cnt;
  logic            c_reg;
  logic            z_reg;

  logic            last_step;
  logic            d_signed;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_nxt;
  logic [PW-1:0]   result;

`ifdef AVR_CPU_ALU_FMUL_EN
  logic            frac_q;
`else
  logic            unused_frac;
  assign unused_frac = frac;
`endif

  // One shift-add step; the multiplier's sign bit carries weight -2^(W-1),
  // so for a signed multiplier the final partial product is subtracted.
  always_comb begin
    last_step = (cnt == CW'(WIDTH - 1));
    d_signed  = (mode == 2'b01) || (mode == 2'b10);
    addend    = '0;
    if (mult[0]) begin
      addend = (last_step && r_signed) ? (PW'(0) - mcand) : mcand;
    end
    acc_nxt = acc + addend;
    result  = acc_nxt;
`ifdef AVR_CPU_ALU_FMUL_EN
    if (frac_q) begin
      result = {acc_nxt[PW-2:0], 1'b0};
    end
`endif
  end

  // Status passes through with C and Z substituted.
  assign status_out = {status_in[7:2], z_reg, c_reg};

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      c_reg    <= 1'b0;
      z_reg    <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mult     <= '0;
      r_signed <= 1'b0;
      cnt      <= '0;
`ifdef AVR_CPU_ALU_FMUL_EN
      frac_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= result;
            c_reg   <= acc_nxt[PW-1];
            z_reg   <= (result == '0);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            mcand    <= d_signed ? {{WIDTH{d_in[WIDTH-1]}}, d_in}
                                 : {{WIDTH{1'b0}}, d_in};
            mult     <= r_in;
            r_signed <= (mode == 2'b01);
`ifdef AVR_CPU_ALU_FMUL_EN
            frac_q   <= frac;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avr_cpu_alu_mul.sv
module tb_avr_cpu_alu_mul;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic          frac;
  logic [W-1:0]  d_in;
  logic [W-1:0]  r_in;
  logic [7:0]    status_in;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic [7:0]    status_out;

  int total = 0;
  int bad   = 0;

  avr_cpu_alu_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .frac(frac),
    .d_in(d_in), .r_in(r_in), .status_in(status_in),
    .busy(busy), .done(done), .product(product), .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_raw(input logic [1:0] m, input logic [W-1:0] d,
                                              input logic [W-1:0] r);
    longint a, b;
    a = (m == 2'b01 || m == 2'b10) ? longint'($signed(d)) : longint'(d);
    b = (m == 2'b01) ? longint'($signed(r)) : longint'(r);
    return (2*W)'(a * b);
  endfunction

  // Behavioural model: cycles since acceptance (0 = idle).
  int              m_cnt = 0;
  bit              m_valid = 0;
  logic [2*W-1:0]  m_prod, m_pend;
  logic            m_c, m_z, m_pc, m_pz;

  always @(posedge clk) begin
    logic [2*W-1:0] p, q;
    if (rst) begin
      m_cnt = 0; m_prod = '0; m_c = 1'b0; m_z = 1'b0;
    end else if (m_cnt >= 1 && m_cnt <= W) begin
      m_cnt++;
      if (m_cnt == W + 1) begin
        m_prod = m_pend; m_c = m_pc; m_z = m_pz;
      end
    end else if (start) begin
      m_cnt = 1;
      p = ref_raw(mode, d_in, r_in);
      q = p;
`ifdef AVR_CPU_ALU_FMUL_EN
      if (frac) q = p << 1;
`endif
      m_pend = q; m_pc = p[2*W-1]; m_pz = (q == '0);
    end else begin
      m_cnt = 0;
    end
    m_valid = 1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= W));
      chk("done", 32'(done), 32'(m_cnt == W + 1));
      chk("product", 32'(product), 32'(m_prod));
      chk("status_out", 32'(status_out), 32'({status_in[7:2], m_z, m_c}));
    end
  end

  int busy_cycles;
  bit got_done;

  // Launch one operation, scramble operands while busy, wait for done (bounded).
  task automatic do_op(input logic [1:0] m, input logic f, input logic [W-1:0] d,
                       input logic [W-1:0] r);
    @(posedge clk); #1;
    start = 1'b1; mode = m; frac = f; d_in = d; r_in = r;
    @(posedge clk); #1;
    start = 1'b0; d_in = W'($urandom); r_in = W'($urandom); mode = 2'($urandom);
    frac = 1'($urandom);
    busy_cycles = 0; got_done = 0;
    for (int i = 0; i < 30 && !got_done; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) got_done = 1;
    end
    chk("done_seen", 32'(got_done), 32'd1);
  endtask

  int done_t[$];

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; frac = 1'b0;
    d_in = '0; r_in = '0; status_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_status", 32'(status_out), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 0xFF * 0xFF unsigned
    do_op(2'b00, 1'b0, 8'hFF, 8'hFF);
    chk("u_busy_cycles", 32'(busy_cycles), 32'd8);
    chk("u_product", 32'(product), 32'hFE01);
    chk("u_c", 32'(status_out[0]), 32'd1);
    chk("u_z", 32'(status_out[1]), 32'd0);

    // -1 * 2 signed, then signed x unsigned
    do_op(2'b01, 1'b0, 8'hFF, 8'h02);
    chk("ss_product", 32'(product), 32'hFFFE);
    chk("ss_c", 32'(status_out[0]), 32'd1);
    do_op(2'b10, 1'b0, 8'hFF, 8'h02);
    chk("su_product", 32'(product), 32'hFFFE);
    do_op(2'b11, 1'b0, 8'hFF, 8'h02);
    chk("m11_product", 32'(product), 32'h01FE);

    // Most-negative squared, integer and fractional
    do_op(2'b01, 1'b0, 8'h80, 8'h80);
    chk("mn_product", 32'(product), 32'h4000);
    chk("mn_c", 32'(status_out[0]), 32'd0);
    do_op(2'b01, 1'b1, 8'h80, 8'h80);
`ifdef AVR_CPU_ALU_FMUL_EN
    chk("fmul_product", 32'(product), 32'h8000);
`else
    chk("fmul_product", 32'(product), 32'h4000);
`endif
    chk("fmul_c", 32'(status_out[0]), 32'd0);
    chk("fmul_z", 32'(status_out[1]), 32'd0);

    // Zero operand with status pass-through
    status_in = 8'hFF;
    do_op(2'b00, 1'b0, 8'h00, 8'hA5);
    chk("zero_product", 32'(product), 32'h0000);
    chk("zero_status", 32'(status_out), 32'hFE);

    // Continuous start: one completion every W+1 cycles
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_t.push_back(i);
      #1; d_in = W'($urandom); r_in = W'($urandom); mode = 2'($urandom);
    end
    start = 1'b0;
    chk("stream_count_ok", 32'(done_t.size() >= 3), 32'd1);
    if (done_t.size() >= 3) begin
      chk("stream_period1", 32'(done_t[1] - done_t[0]), 32'd9);
      chk("stream_period2", 32'(done_t[2] - done_t[1]), 32'd9);
    end
    repeat (12) @(posedge clk);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b00; d_in = 8'h12; r_in = 8'h34;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    got_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    chk("abort_no_done", 32'(got_done), 32'd0);
    do_op(2'b00, 1'b0, 8'h12, 8'h34);
    chk("after_abort_product", 32'(product), 32'h03A8);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 3) == 0);
      mode      = 2'($urandom);
      frac      = 1'($urandom);
      d_in      = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom);
      r_in      = ($urandom_range(0, 9) == 0) ? 8'h80 : W'($urandom);
      status_in = 8'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
